snake_core: RTL and testbench

Parametrised snake engine: owns the snake body, movement timing, direction control, growth and collision detection for a grid of any size. Sits between the debounced key-press pulses and the VGA renderer. It replaces the fixed-length, fixed-grid snake logic. It adds a ring-buffer body up to `MAX_LEN` segments, a registered pixel-cell query port, and optional edge wrap-around.

---
 rtl/snake_core.sv | 262 ++++++++++++++++++++++++++
 tb/tb_snake_core.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_core.sv
// snake_core: parametrised snake engine for the VGA snake game.
// Keeps the body in a ring buffer and handles move timing, direction
// control, growth, collision detection and a registered pixel-cell query.
// Optional feature: define SNAKE_WRAP_EN to make the head wrap around the
// grid edges instead of dying on them.
module snake_core #(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int MAX_LEN     = 32,
  parameter int INIT_LEN    = 3,
  parameter int TICK_DIV    = 12_500_000,
  parameter int FLASH_STEPS = 8,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          dir_valid,
  input  logic [1:0]    dir_req,
  input  logic          grow,
  input  logic [XW-1:0] qx,
  input  logic [YW-1:0] qy,
  output logic [1:0]    q_seg,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] len,
  output logic [1:0]    state,
  output logic          moved,
  output logic          hit_wall,
  output logic          hit_body,
  output logic          die_flash
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(FLASH_STEPS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DIE  = 2'b10,
    ST_DEAD = 2'b11
  } state_t;

  // Body ring buffer: segment i lives at index (hp_r - i) mod MAX_LEN.
  logic [MAX_LEN-1:0][XW-1:0] seg_x_r;
  logic [MAX_LEN-1:0][YW-1:0] seg_y_r;
  logic [PW-1:0]              hp_r;
  state_t                     state_r;
  logic [1:0]                 dir_r;
  logic [1:0]                 pend_r;
  logic                       grow_r;
  logic [TW-1:0]              tick_r;
  logic [FW-1:0]              flash_cnt_r;
  logic [XW-1:0]              head_x_r;
  logic [YW-1:0]              head_y_r;
  logic [LW-1:0]              len_r;
  logic                       moved_r;
  logic                       hit_wall_r;
  logic                       hit_body_r;
  logic                       die_flash_r;
  logic [1:0]                 q_seg_r;

  logic          run_s;
  logic          step_s;
  logic          restart_s;
  logic [XW-1:0] nx_s;
  logic [YW-1:0] ny_s;
  logic          edge_s;
  logic          wall_s;
  logic          grow_eff_s;
  logic [LW-1:0] lim_s;
  logic          body_hit_s;
  logic          q_head_s;
  logic          q_body_s;
  logic [1:0]    q_next_s;

  assign run_s     = (state_r == ST_RUN) || (state_r == ST_DIE);
  assign step_s    = run_s && (tick_r == TW'(TICK_DIV - 1));
  assign restart_s = (state_r == ST_DEAD) && start;

  // Next head cell from the pending direction; edge_s flags leaving the grid.
  always_comb begin
    nx_s   = head_x_r;
    ny_s   = head_y_r;
    edge_s = 1'b0;
    case (pend_r)
      2'b00: begin
        if (head_y_r == YW'(0)) begin
          ny_s   = YW'(GRID_H - 1);
          edge_s = 1'b1;
        end else begin
          ny_s = head_y_r - YW'(1);
        end
      end
      2'b01: begin
        if (head_y_r == YW'(GRID_H - 1)) begin
          ny_s   = YW'(0);
          edge_s = 1'b1;
        end else begin
          ny_s = head_y_r + YW'(1);
        end
      end
      2'b10: begin
        if (head_x_r == XW'(0)) begin
          nx_s   = XW'(GRID_W - 1);
          edge_s = 1'b1;
        end else begin
          nx_s = head_x_r - XW'(1);
        end
      end
      default: begin
        if (head_x_r == XW'(GRID_W - 1)) begin
          nx_s   = XW'(0);
          edge_s = 1'b1;
        end else begin
          nx_s = head_x_r + XW'(1);
        end
      end
    endcase
  end

  // Collision: wall (unless wrapping) or any body segment that is still there after the move.
  always_comb begin
`ifdef SNAKE_WRAP_EN
    wall_s = 1'b0;
`else
    wall_s = edge_s;
`endif
    grow_eff_s = grow_r && (len_r < LW'(MAX_LEN));
    // The tail only vacates its cell when the snake is not growing.
    lim_s      = grow_eff_s ? len_r : (len_r - LW'(1));
    body_hit_s = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      body_hit_s = body_hit_s | ((LW'(i) < lim_s) &&
                                 (seg_x_r[hp_r - PW'(i)] == nx_s) &&
                                 (seg_y_r[hp_r - PW'(i)] == ny_s));
    end
    body_hit_s = body_hit_s & ~wall_s;
  end

  // Pixel query against the live body; head wins, blanked during flash-on.
  always_comb begin
    q_head_s = (head_x_r == qx) && (head_y_r == qy);
    q_body_s = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      q_body_s = q_body_s | ((LW'(i) < len_r) &&
                             (seg_x_r[hp_r - PW'(i)] == qx) &&
                             (seg_y_r[hp_r - PW'(i)] == qy));
    end
    if ((state_r == ST_DIE) && die_flash_r) begin
      q_next_s = 2'b00;
    end else if (q_head_s) begin
      q_next_s = 2'b01;
    end else if (q_body_s) begin
      q_next_s = 2'b10;
    end else begin
      q_next_s = 2'b00;
    end
  end

  // Game FSM, body buffer and registered outputs; reset and restart share the init path.
  always_ff @(posedge clk) begin
    if (!reset || restart_s) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if (j < INIT_LEN) begin
          seg_x_r[j] <= XW'(GRID_W / 2 - (INIT_LEN - 1 - j));
        end else begin
          seg_x_r[j] <= XW'(0);
        end
        seg_y_r[j] <= YW'(GRID_H / 2);
      end
      hp_r        <= PW'(INIT_LEN - 1);
      head_x_r    <= XW'(GRID_W / 2);
      head_y_r    <= YW'(GRID_H / 2);
      len_r       <= LW'(INIT_LEN);
      dir_r       <= 2'b11;
      pend_r      <= 2'b11;
      grow_r      <= 1'b0;
      tick_r      <= TW'(0);
      flash_cnt_r <= FW'(0);
      moved_r     <= 1'b0;
      hit_wall_r  <= 1'b0;
      hit_body_r  <= 1'b0;
      die_flash_r <= 1'b0;
      q_seg_r     <= 2'b00;
      state_r     <= reset ? ST_RUN : ST_IDLE;
    end else begin
      moved_r <= 1'b0;
      q_seg_r <= q_next_s;
      if (dir_valid && (dir_req != (dir_r ^ 2'b01))) begin
        pend_r <= dir_req;
      end
      if (grow) begin
        grow_r <= 1'b1;
      end
      if (run_s) begin
        tick_r <= step_s ? TW'(0) : (tick_r + TW'(1));
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_RUN;
            tick_r  <= TW'(0);
          end
        end
        ST_RUN: begin
          if (step_s) begin
            dir_r <= pend_r;
            if (wall_s || body_hit_s) begin
              state_r     <= ST_DIE;
              hit_wall_r  <= hit_wall_r | wall_s;
              hit_body_r  <= hit_body_r | body_hit_s;
              grow_r      <= 1'b0;
              flash_cnt_r <= FW'(0);
              die_flash_r <= 1'b0;
            end else begin
              hp_r                    <= hp_r + PW'(1);
              seg_x_r[hp_r + PW'(1)]  <= nx_s;
              seg_y_r[hp_r + PW'(1)]  <= ny_s;
              head_x_r                <= nx_s;
              head_y_r                <= ny_s;
              len_r                   <= grow_eff_s ? (len_r + LW'(1)) : len_r;
              grow_r                  <= grow;
              moved_r                 <= 1'b1;
            end
          end
        end
        ST_DIE: begin
          if (step_s) begin
            if (flash_cnt_r == FW'(FLASH_STEPS - 1)) begin
              state_r     <= ST_DEAD;
              die_flash_r <= 1'b0;
            end else begin
              flash_cnt_r <= flash_cnt_r + FW'(1);
              die_flash_r <= ~die_flash_r;
            end
          end
        end
        ST_DEAD: begin
          state_r <= ST_DEAD;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign q_seg     = q_seg_r;
  assign head_x    = head_x_r;
  assign head_y    = head_y_r;
  assign len       = len_r;
  assign state     = state_r;
  assign moved     = moved_r;
  assign hit_wall  = hit_wall_r;
  assign hit_body  = hit_body_r;
  assign die_flash = die_flash_r;

endmodule

// File: tb/tb_snake_core.sv
// tb_snake_core: directed scenarios plus randomized play, every cycle
// compared against a queue-based behavioural model of the snake game.
module tb_snake_core;
  localparam int W = 8, H = 8, ML = 8, IL = 3, TD = 4, FS = 4;

  logic       clk = 1'b0;
  logic       reset, start, dir_valid, grow;
  logic [1:0] dir_req;
  logic [2:0] qx, qy;
  logic [1:0] q_seg, state;
  logic [2:0] head_x, head_y;
  logic [3:0] len;
  logic       moved, hit_wall, hit_body, die_flash;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: body as a queue, index 0 = head.
  int bx[$];
  int by[$];
  int m_state, m_tick, m_dir, m_pend, m_fcnt, m_q;
  bit m_grow, m_moved, m_hw, m_hb, m_flash;

  snake_core #(
    .GRID_W(W), .GRID_H(H), .MAX_LEN(ML), .INIT_LEN(IL),
    .TICK_DIV(TD), .FLASH_STEPS(FS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dir_valid(dir_valid),
    .dir_req(dir_req), .grow(grow), .qx(qx), .qy(qy), .q_seg(q_seg),
    .head_x(head_x), .head_y(head_y), .len(len), .state(state),
    .moved(moved), .hit_wall(hit_wall), .hit_body(hit_body),
    .die_flash(die_flash)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_init();
    bx.delete();
    by.delete();
    for (int i = 0; i < IL; i++) begin
      bx.push_back(W / 2 - i);
      by.push_back(H / 2);
    end
    m_dir = 3; m_pend = 3; m_grow = 0; m_tick = 0; m_fcnt = 0;
    m_moved = 0; m_hw = 0; m_hb = 0; m_flash = 0; m_q = 0;
  endtask

  function automatic int m_query(input int x, input int y);
    if (m_state == 2 && m_flash) return 0;
    if (bx[0] == x && by[0] == y) return 1;
    for (int k = 1; k < bx.size(); k++)
      if (bx[k] == x && by[k] == y) return 2;
    return 0;
  endfunction

  // Advance the model by one clock using the inputs applied in that cycle.
  task automatic m_clock(input bit st, input bit dv, input logic [1:0] dr, input bit gr);
    bit step, old_grow, wall, bodyh, growing;
    int old_pend, nx, ny;
    if (!reset) begin m_init(); m_state = 0; return; end
    if (m_state == 3 && st) begin m_init(); m_state = 1; return; end
    m_q = m_query(int'(qx), int'(qy));
    m_moved = 0;
    step = (m_state == 1 || m_state == 2) && (m_tick == TD - 1);
    if (m_state == 1 || m_state == 2) m_tick = step ? 0 : m_tick + 1;
    old_pend = m_pend;
    old_grow = m_grow;
    if (dv && int'(dr) != (m_dir ^ 1)) m_pend = int'(dr);
    if (gr) m_grow = 1;
    case (m_state)
      0: if (st) begin m_state = 1; m_tick = 0; end
      1: if (step) begin
        m_dir = old_pend;
        nx = bx[0]; ny = by[0];
        case (old_pend)
          0: ny = ny - 1;
          1: ny = ny + 1;
          2: nx = nx - 1;
          default: nx = nx + 1;
        endcase
        wall = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
`ifdef SNAKE_WRAP_EN
        nx = (nx + W) % W;
        ny = (ny + H) % H;
        wall = 0;
`endif
        growing = old_grow && (bx.size() < ML);
        bodyh = 0;
        if (!wall)
          for (int k = 1; k < bx.size(); k++)
            if ((growing || k != bx.size() - 1) && bx[k] == nx && by[k] == ny) bodyh = 1;
        if (wall || bodyh) begin
          m_state = 2; m_hw = m_hw | wall; m_hb = m_hb | bodyh;
          m_grow = 0; m_fcnt = 0; m_flash = 0;
        end else begin
          bx.push_front(nx); by.push_front(ny);
          if (!growing) begin void'(bx.pop_back()); void'(by.pop_back()); end
          m_moved = 1;
          m_grow = gr;
        end
      end
      2: if (step) begin
        m_fcnt++;
        if (m_fcnt == FS) begin m_state = 3; m_flash = 0; end
        else m_flash = !m_flash;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("head_x", head_x, bx[0]);
    check("head_y", head_y, by[0]);
    check("len", len, bx.size());
    check("state", state, m_state);
    check("moved", moved, m_moved);
    check("hit_wall", hit_wall, m_hw);
    check("hit_body", hit_body, m_hb);
    check("die_flash", die_flash, m_flash);
    check("q_seg", q_seg, m_q);
  endtask

  task automatic cyc(input bit st, input bit dv, input logic [1:0] dr, input bit gr);
    start = st; dir_valid = dv; dir_req = dr; grow = gr;
    @(posedge clk);
    #1;
    m_clock(st, dv, dr, gr);
    compare_all();
    start = 1'b0; dir_valid = 1'b0; grow = 1'b0;
  endtask

  // One move period: optional direction on its first cycle, ng grow pulses.
  task automatic group(input bit dv, input logic [1:0] dr, input int ng);
    for (int k = 0; k < TD; k++) cyc(1'b0, dv && (k == 0), dr, k < ng);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    bit st, dv, gr;
    logic [1:0] dr;
    reset = 1'b0; start = 1'b0; dir_valid = 1'b0; dir_req = 2'b00;
    grow = 1'b0; qx = 3'd0; qy = 3'd0;
    m_state = 0;
    m_init();

    // Reset and start
    do_reset();
    check("rst_state", state, 0);
    check("rst_head_x", head_x, 4);
    check("rst_len", len, 3);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    check("start_state", state, 1);
    group(1'b0, 2'b00, 0);
    check("step1_x", head_x, 5);
    check("step1_moved", moved, 1);
    group(1'b0, 2'b00, 0);
    check("step2_x", head_x, 6);

    // Reversal dropped, then turn up
    group(1'b1, 2'b10, 0);
    check("rev_x", head_x, 7);
    group(1'b1, 2'b00, 0);
    check("up_y", head_y, 3);

    // Growth with multiple pulses per period and saturation
    group(1'b1, 2'b10, 3);
    check("grow_len4", len, 4);
    for (int g = 5; g <= 9; g++) begin
      group(1'b0, 2'b00, 3);
      check("grow_len", len, (g > ML) ? ML : g);
    end

    // Wall run from the initial position
    do_reset();
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    for (int s = 0; s < 3; s++) group(1'b0, 2'b00, 0);
    check("wall_x7", head_x, 7);
    group(1'b0, 2'b00, 0);
`ifdef SNAKE_WRAP_EN
    check("wrap_state", state, 1);
    check("wrap_x", head_x, 0);
    check("wrap_hit_wall", hit_wall, 0);
    do_reset();
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
`else
    check("wall_state", state, 2);
    check("wall_hit", hit_wall, 1);
    for (int s = 0; s < FS; s++) group(1'b0, 2'b00, 0);
    check("dead_state", state, 3);
    check("dead_flash", die_flash, 0);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    check("restart_state", state, 1);
    check("restart_x", head_x, 4);
    check("restart_hit_wall", hit_wall, 0);
`endif

    // Body hit and query
    group(1'b0, 2'b00, 1);
    group(1'b0, 2'b00, 1);
    check("body_len5", len, 5);
    group(1'b1, 2'b00, 0);
    group(1'b1, 2'b10, 0);
    group(1'b1, 2'b01, 0);
    check("body_state", state, 2);
    check("body_hit", hit_body, 1);
    qx = 3'd5; qy = 3'd3; cyc(1'b0, 1'b0, 2'b00, 1'b0);
    check("q_head", q_seg, 1);
    qx = 3'd6; qy = 3'd3; cyc(1'b0, 1'b0, 2'b00, 1'b0);
    check("q_body", q_seg, 2);
    qx = 3'd0; qy = 3'd0; cyc(1'b0, 1'b0, 2'b00, 1'b0);
    check("q_empty", q_seg, 0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    qx = 3'd5; qy = 3'd3; cyc(1'b0, 1'b0, 2'b00, 1'b0);
    check("q_flash_blank", q_seg, 0);
    for (int c = 0; c < 11; c++) cyc(1'b0, 1'b0, 2'b00, 1'b0);
    check("body_dead", state, 3);
    qx = 3'd6; qy = 3'd4; cyc(1'b0, 1'b0, 2'b00, 1'b0);
    check("q_dead_body", q_seg, 2);

    // Randomized play
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      qx = 3'($urandom_range(0, W - 1));
      qy = 3'($urandom_range(0, H - 1));
      reset = ($urandom_range(0, 499) != 0);
      if (m_state == 0 || m_state == 3) st = ($urandom_range(0, 3) == 0);
      else st = ($urandom_range(0, 31) == 0);
      dv = (m_tick != TD - 1) && ($urandom_range(0, 5) == 0);
      gr = (m_tick != TD - 1) && ($urandom_range(0, 9) == 0);
      dr = 2'($urandom_range(0, 3));
      cyc(st, dv, dr, gr);
      reset = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
